// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: multi-cycle MULT/DIV plus MTHI/MTLO, and it owns the HI/LO registers.
// While busy it ignores start. MFHI/MFLO reads come out combinationally on MD_out.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI_out,
   output logic [31:0] LO_out,
   output logic [31:0] MD_out
);

   typedef enum logic [2:0] {
      OP_MULT  = 3'd0,
      OP_MULTU = 3'd1,
      OP_DIV   = 3'd2,
      OP_DIVU  = 3'd3,
      OP_MTHI  = 3'd4,
      OP_MTLO  = 3'd5,
      OP_MFHI  = 3'd6,
      OP_MFLO  = 3'd7
   } op_t;

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t      state, state_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [31:0] hi, hi_nxt, lo, lo_nxt;
   logic [31:0] a_q, b_q;
   op_t         op_q;
   logic        cap;

   logic [63:0] prod_s, prod_u;
   logic [31:0] a_mag, b_mag, b_safe, bs_safe;
   logic [31:0] qs_mag, rs_mag, q_s, r_s, q_u, r_u;
   logic [31:0] res_hi, res_lo;
   logic        res_we;

   // Datapath works only on the latched operands, so A/B may change freely while busy.
   always_comb begin
      prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
      prod_u  = {32'b0, a_q} * {32'b0, b_q};
      a_mag   = a_q[31] ? (~a_q + 32'd1) : a_q;
      b_mag   = b_q[31] ? (~b_q + 32'd1) : b_q;
      b_safe  = (b_q == '0) ? 32'd1 : b_q;
      bs_safe = (b_q == '0) ? 32'd1 : b_mag;
      // Magnitude division keeps 0x80000000 / -1 well defined (quotient wraps to 0x80000000).
      qs_mag  = a_mag / bs_safe;
      rs_mag  = a_mag % bs_safe;
      q_s     = (a_q[31] ^ b_q[31]) ? (~qs_mag + 32'd1) : qs_mag;
      r_s     = a_q[31] ? (~rs_mag + 32'd1) : rs_mag;
      q_u     = a_q / b_safe;
      r_u     = a_q % b_safe;
   end

   always_comb begin
      res_hi = hi;
      res_lo = lo;
      res_we = 1'b0;
      case (op_q)
         OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_we = 1'b1; end
         OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_we = 1'b1; end
         OP_DIV:   begin res_hi = r_s; res_lo = q_s; res_we = (b_q != '0); end
         OP_DIVU:  begin res_hi = r_u; res_lo = q_u; res_we = (b_q != '0); end
         default:  ;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      hi_nxt    = hi;
      lo_nxt    = lo;
      cap       = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               case (op_t'(op))
                  OP_MULT, OP_MULTU: begin
                     state_nxt = S_BUSY;
                     cnt_nxt   = 32'(MULT_CYCLES);
                     cap       = 1'b1;
                  end
                  OP_DIV, OP_DIVU: begin
                     state_nxt = S_BUSY;
                     cnt_nxt   = 32'(DIV_CYCLES);
                     cap       = 1'b1;
                  end
                  OP_MTHI: hi_nxt = A;
                  OP_MTLO: lo_nxt = A;
                  default: ;
               endcase
            end
         end
         S_BUSY: begin
            if (cnt == 32'd1) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
               if (res_we) begin
                  hi_nxt = res_hi;
                  lo_nxt = res_lo;
               end
            end else begin
               cnt_nxt = cnt - 32'd1;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         a_q   <= '0;
         b_q   <= '0;
         op_q  <= OP_MULT;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         hi    <= hi_nxt;
         lo    <= lo_nxt;
         if (cap) begin
            a_q  <= A;
            b_q  <= B;
            op_q <= op_t'(op);
         end
      end
   end

   assign busy   = (state == S_BUSY);
   assign HI_out = hi;
   assign LO_out = lo;
   assign MD_out = (op == 3'd6) ? hi : (op == 3'd7) ? lo : '0;

endmodule

// File: tb/tb_e_mdu.sv
// Directed bench for e_mdu. Each expected HI/LO pair is queued when its op issues.
// The pair is popped and checked at the cycle where busy falls.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] HI_out, LO_out, MD_out;

   int unsigned tests = 0;
   int unsigned fails = 0;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;
   exp_t sb[$];

   e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
      .busy(busy), .HI_out(HI_out), .LO_out(LO_out), .MD_out(MD_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; A = a; B = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Called on the negedge after acceptance. It counts busy cycles and checks HI/LO hold,
   // then pops the queued expectation. With disturb set, it scrambles A/B each cycle
   // and pulses MTLO 0x55 at the third busy cycle.
   task automatic finish_op(input int n, input bit disturb);
      logic [31:0] old_hi, old_lo;
      int          cyc, held_bad, lo55;
      exp_t        e;
      old_hi = HI_out; old_lo = LO_out;
      cyc = 0; held_bad = 0; lo55 = 0;
      while (busy && cyc < 40) begin
         cyc++;
         if (HI_out !== old_hi || LO_out !== old_lo) held_bad++;
         if (LO_out === 32'h55) lo55++;
         if (disturb) begin
            A = $urandom; B = $urandom;
            if (cyc == 3) begin start = 1'b1; op = 3'd5; A = 32'h55; end
            else start = 1'b0;
         end
         @(negedge clk);
      end
      if (disturb) start = 1'b0;
      if (LO_out === 32'h55) lo55++;
      if (sb.size() == 0) begin
         chk("sb_empty", 32'(sb.size()), 32'd1);
         return;
      end
      e = sb.pop_front();
      chk({e.tag, "_busy_cycles"}, 32'(cyc), 32'(n));
      chk({e.tag, "_hold"}, 32'(held_bad), 32'd0);
      chk({e.tag, "_HI"}, HI_out, e.hi);
      chk({e.tag, "_LO"}, LO_out, e.lo);
      if (disturb) chk({e.tag, "_lo_never_55"}, 32'(lo55), 32'd0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // 1: reset state, MF reads, async reset mid-divide
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_HI", HI_out, 32'h0);
      chk("rst_LO", LO_out, 32'h0);
      op = 3'd6; #1 chk("rst_MD_hi", MD_out, 32'h0);
      op = 3'd7; #1 chk("rst_MD_lo", MD_out, 32'h0);
      issue(3'd4, 32'hA5A5_0001, 32'h0);
      issue(3'd5, 32'h5A5A_0002, 32'h0);
      op = 3'd0; #1 chk("md_other_op_zero", MD_out, 32'h0);
      issue(3'd2, 32'd100, 32'd3);
      repeat (6) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_HI", HI_out, 32'h0);
      chk("midrst_LO", LO_out, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      repeat (12) @(negedge clk);
      chk("postrst_busy", {31'b0, busy}, 32'd0);
      chk("postrst_HI", HI_out, 32'h0);
      chk("postrst_LO", LO_out, 32'h0);

      // 2: MULT / MULTU
      sb.push_back('{"mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA});
      issue(3'd0, 32'hFFFF_FFFE, 32'd3);
      finish_op(5, 1'b0);
      sb.push_back('{"multu", 32'h0000_0002, 32'hFFFF_FFFA});
      issue(3'd1, 32'hFFFF_FFFE, 32'd3);
      finish_op(5, 1'b0);

      // 3: DIV / DIVU, including the signed overflow case
      sb.push_back('{"div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD});
      issue(3'd2, 32'hFFFF_FFF9, 32'd2);
      finish_op(10, 1'b0);
      sb.push_back('{"divu", 32'd1, 32'd3});
      issue(3'd3, 32'd7, 32'd2);
      finish_op(10, 1'b0);
      sb.push_back('{"div_ovf", 32'h0, 32'h8000_0000});
      issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
      finish_op(10, 1'b0);

      // 4: MTHI/MTLO, then divide by zero leaves HI/LO, then MFHI
      issue(3'd4, 32'h11, 32'h0);
      chk("mthi_busy", {31'b0, busy}, 32'd0);
      chk("mthi_HI", HI_out, 32'h11);
      issue(3'd5, 32'h22, 32'h0);
      chk("mtlo_busy", {31'b0, busy}, 32'd0);
      chk("mtlo_LO", LO_out, 32'h22);
      sb.push_back('{"div0", 32'h11, 32'h22});
      issue(3'd2, 32'd1234, 32'd0);
      finish_op(10, 1'b0);
      issue(3'd6, 32'h0, 32'h0);
      op = 3'd6; #1;
      chk("mfhi_MD", MD_out, 32'h11);
      chk("mfhi_busy", {31'b0, busy}, 32'd0);

      // 5: operands and start ignored while busy
      sb.push_back('{"mult_disturb", 32'h0, 32'd63});
      issue(3'd0, 32'd7, 32'd9);
      finish_op(5, 1'b1);

      // 6: start held through completion; next op accepted one cycle after busy falls
      sb.push_back('{"mult_b2b", 32'h0, 32'd20});
      @(negedge clk);
      start = 1'b1; op = 3'd0; A = 32'd4; B = 32'd5;
      @(negedge clk);
      op = 3'd3; A = 32'd100; B = 32'd7;
      finish_op(5, 1'b0);
      chk("b2b_not_on_fall", {31'b0, busy}, 32'd0);
      @(negedge clk);
      chk("b2b_accepted", {31'b0, busy}, 32'd1);
      start = 1'b0;
      sb.push_back('{"divu_b2b", 32'd2, 32'd14});
      finish_op(10, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the E stage, alongside the ALU, directly upstream of the E/M pipeline register.
- Executes MULT, MULTU, DIV, DIVU, MTHI, MTLO and holds the architectural HI/LO registers.
- Serves MFHI/MFLO reads combinationally to the E-stage result mux, which forwards them into the E/M register.
- Asserts busy so the hazard unit can stall dependent MD instructions.

Parameters:
MULT_CYCLES  5   busy duration in cycles for MULT/MULTU (>=1)
DIV_CYCLES   10  busy duration in cycles for DIV/DIVU (>=1)

Ports:
clk      input   1   system clock, rising edge
reset    input   1   asynchronous, active-high reset
start    input   1   E-stage instruction is an MD op; qualifies op
op       input   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO
A        input   32  rs operand (already forwarded)
B        input   32  rt operand (already forwarded)
busy     output  1   multi-cycle operation in flight
HI_out   output  32  current HI register
LO_out   output  32  current LO register
MD_out   output  32  op==6 ? HI : op==7 ? LO : 0 (combinational)

Behaviour:
- Reset, asynchronous, effective immediately (also mid-operation):
  - busy=0, counter=0, HI=0, LO=0.
  - Captured operands and op are cleared.
  - Any in-flight result is discarded.
- Accept condition: start=1 and busy=0, sampled at a rising edge. If busy=1, start is ignored entirely for every op; no queueing.
- MULT/MULTU/DIV/DIVU accepted at edge t0:
  - Latch A, B and op internally.
  - busy=1 and counter=N after t0, where N = MULT_CYCLES or DIV_CYCLES.
  - Counter decrements at each later edge.
  - At the edge where counter==1: HI/LO <= result, busy <= 0, counter <= 0. busy is therefore high for exactly N cycles.
  - HI/LO keep their old values until that final edge.
  - Result is computed from the latched operands, so A/B changes during busy have no effect.
- MULT: {HI,LO} = signed A × signed B, full 64-bit result.
- MULTU: {HI,LO} = unsigned A × unsigned B, full 64-bit result.
- DIV (signed):
  - LO = quotient, truncated toward zero.
  - HI = remainder, with the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DIVU: LO = A/B, HI = A%B, unsigned.
- Divide by zero (B==0, DIV or DIVU):
  - busy still asserted for DIV_CYCLES.
  - HI and LO unchanged at completion.
- MTHI/MTLO accepted at edge t0:
  - HI <= A (resp. LO <= A) at t0.
  - busy stays 0; single-cycle.
- MFHI/MFLO:
  - No state change.
  - MD_out reflects the current HI/LO combinationally, including a value written at the previous edge.
  - If issued while busy=1, MD_out shows the stale register; the hazard unit must stall MF* while busy.
- Completion edge vs new start: at the edge where busy falls, busy is still 1, so start is ignored. The next op is accepted one cycle later.
- No other state: no pipeline flush input. A killed MD op must have start deasserted by the stage logic.

Test Plan:
1. Reset then idle → busy=0, HI_out=LO_out=0, MD_out=0 for op=6 and op=7. Assert reset mid-DIV (counter=4) → busy drops immediately; HI/LO=0 and stay 0 after deassert.
2. MULT, A=0xFFFFFFFE (−2), B=3, start 1 cycle → busy high exactly 5 cycles; HI/LO unchanged during busy; then HI=0xFFFFFFFF, LO=0xFFFFFFFA. MULTU same operands → HI=0x00000002, LO=0xFFFFFFFA.
3. DIV, A=0xFFFFFFF9 (−7), B=2 → busy 10 cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1). DIVU 7/2 → LO=3, HI=1. DIV 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
4. Preload HI=0x11, LO=0x22 via MTHI/MTLO (each 1 cycle, busy stays 0), then DIV with B=0 → busy 10 cycles, HI=0x11, LO=0x22 after completion. MFHI next cycle → MD_out=0x11.
5. MULT accepted; change A/B each busy cycle and pulse start with MTLO, A=0x55, at cycle 3 → result uses the original operands; MTLO ignored; LO never equals 0x55.
6. MULT, then start held continuously with DIVU 100/7 → DIVU not accepted on the edge where busy falls, accepted on the following edge; busy rises again for 10 cycles; final LO=14, HI=2.
